// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory port arbiter.
//   - arb_state_t : FSM state encoding (IDLE=0, ACCESS=1, WAIT=2, DONE=3)
//   - OWN_*       : owner codes reported on the owner output
//   - CNT_W       : width of the read-latency counter
//   - own_onehot  : owner code to {ld, dm, if} one-hot strobe vector
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } arb_state_t;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_IF   = 2'd1;
    localparam logic [1:0] OWN_DM   = 2'd2;
    localparam logic [1:0] OWN_LD   = 2'd3;

    localparam int CNT_W = 4;

    // Bit order is {ld, dm, if}.
    function automatic logic [2:0] own_onehot(input logic [1:0] own);
        logic [2:0] v;
        v = 3'b000;
        case (own)
            OWN_IF:  v = 3'b001;
            OWN_DM:  v = 3'b010;
            OWN_LD:  v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection for the memory port arbiter.
// Ports:
//   i_if_req, i_dm_req, i_ld_req : pending requests
//   i_rr_if_pri                  : 1 = fetch wins an if/dm tie, 0 = data wins
//   o_owner                      : winning owner code (OWN_NONE if no request)
//   o_rr_upd                     : 1 when the winner is if or dm, so the
//                                  round-robin pointer must advance
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       i_if_req,
    input  logic       i_dm_req,
    input  logic       i_ld_req,
    input  logic       i_rr_if_pri,
    output logic [1:0] o_owner,
    output logic       o_rr_upd
);

    always_comb begin
        o_owner  = OWN_NONE;
        o_rr_upd = 1'b0;
        if (i_ld_req) begin
            // Loader overrides everything and leaves the pointer untouched.
            o_owner = OWN_LD;
        end else if (i_if_req && i_dm_req) begin
            o_owner  = i_rr_if_pri ? OWN_IF : OWN_DM;
            o_rr_upd = 1'b1;
        end else if (i_if_req) begin
            o_owner  = OWN_IF;
            o_rr_upd = 1'b1;
        end else if (i_dm_req) begin
            o_owner  = OWN_DM;
            o_rr_upd = 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous RAM port between instruction
// fetch (if), data load/store (dm) and the boot/debug loader (ld).
// One transaction at a time: IDLE -> ACCESS -> [WAIT x LAT] -> DONE -> IDLE.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   if_req/if_addr               : fetch read request
//   dm_*/ld_*                    : data and loader requests (we=1 write)
//   *_gnt                        : one-cycle pulse in the ACCESS cycle
//   *_done                       : one-cycle pulse when the transaction ends
//   rdata                        : registered read data, valid with *_done
//   busy, owner                  : status (owner 0 none, 1 if, 2 dm, 3 ld)
//   mem_en/we/addr/wdata         : RAM command, non-zero only in ACCESS
//   mem_rdata                    : RAM read data, LAT cycles after mem_en
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          dm_req,
    input  logic          dm_we,
    input  logic [AW-1:0] dm_addr,
    input  logic [DW-1:0] dm_wdata,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          if_gnt,
    output logic          dm_gnt,
    output logic          ld_gnt,
    output logic          if_done,
    output logic          dm_done,
    output logic          ld_done,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic [1:0]    owner,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic [1:0]       r_owner;
    logic [AW-1:0]    r_addr;
    logic             r_we;
    logic [DW-1:0]    r_wdata;
    logic [CNT_W-1:0] r_cnt;
    logic             r_rr_if_pri;
    logic [2:0]       r_gnt;   // {ld, dm, if}
    logic [2:0]       r_done;  // {ld, dm, if}
    logic [DW-1:0]    r_rdata;
    logic             r_busy;

    logic [1:0]       w_win;
    logic             w_rr_upd;
    logic             w_any_req;
    logic             w_cnt_last;
    logic [AW-1:0]    w_sel_addr;
    logic             w_sel_we;
    logic [DW-1:0]    w_sel_wdata;
    logic             w_access;

    mem_arb_pick u_pick (
        .i_if_req    (if_req),
        .i_dm_req    (dm_req),
        .i_ld_req    (ld_req),
        .i_rr_if_pri (r_rr_if_pri),
        .o_owner     (w_win),
        .o_rr_upd    (w_rr_upd)
    );

    assign w_any_req  = if_req | dm_req | ld_req;
    assign w_cnt_last = (r_cnt == CNT_W'(1));

    // Winner's command, captured on IDLE -> ACCESS. Fetch is always a read.
    always_comb begin
        w_sel_addr  = '0;
        w_sel_we    = 1'b0;
        w_sel_wdata = '0;
        case (w_win)
            OWN_IF: begin
                w_sel_addr = if_addr;
            end
            OWN_DM: begin
                w_sel_addr  = dm_addr;
                w_sel_we    = dm_we;
                w_sel_wdata = dm_wdata;
            end
            OWN_LD: begin
                w_sel_addr  = ld_addr;
                w_sel_we    = ld_we;
                w_sel_wdata = ld_wdata;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any_req) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = r_we ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (w_cnt_last) w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWN_NONE;
            r_addr      <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_rr_if_pri <= 1'b0;  // dm wins the first tie
            r_gnt       <= '0;
            r_done      <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= '0;
            r_done  <= '0;
            r_busy  <= (w_state_nxt != ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_win;
                        r_addr  <= w_sel_addr;
                        r_we    <= w_sel_we;
                        r_wdata <= w_sel_wdata;
                        r_gnt   <= own_onehot(w_win);
                        // The side just served loses the next tie.
                        if (w_rr_upd) r_rr_if_pri <= (w_win == OWN_DM);
                    end
                end
                ST_ACCESS: begin
                    if (r_we) r_done <= own_onehot(r_owner);
                    else      r_cnt  <= CNT_W'(LAT);
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (w_cnt_last) begin
                        r_rdata <= mem_rdata;
                        r_done  <= own_onehot(r_owner);
                    end
                end
                ST_DONE: begin
                    r_owner <= OWN_NONE;
                end
                default: ;
            endcase
        end
    end

    assign if_gnt  = r_gnt[0];
    assign dm_gnt  = r_gnt[1];
    assign ld_gnt  = r_gnt[2];
    assign if_done = r_done[0];
    assign dm_done = r_done[1];
    assign ld_done = r_done[2];
    assign rdata   = r_rdata;
    assign busy    = r_busy;
    assign owner   = r_owner;

    // RAM command decodes straight from state so it drops in the reset cycle.
    assign w_access  = (r_state == ST_ACCESS);
    assign mem_en    = w_access;
    assign mem_we    = w_access & r_we;
    assign mem_addr  = w_access ? r_addr  : '0;
    assign mem_wdata = w_access ? r_wdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: DUT "a" uses LAT=1, DUT "b" uses LAT=3; each has its own
// RAM model whose read data is only non-zero in the cycle it is due.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // ---- DUT a (LAT=1) ----
    logic        a_if_req, a_dm_req, a_dm_we, a_ld_req, a_ld_we;
    logic [31:0] a_if_addr, a_dm_addr, a_dm_wdata, a_ld_addr, a_ld_wdata;
    logic        a_if_gnt, a_dm_gnt, a_ld_gnt, a_if_done, a_dm_done, a_ld_done;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic        a_busy, a_mem_en, a_mem_we;
    logic [1:0]  a_owner;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(1)) u_a (
        .clk(clk), .rst(rst),
        .if_req(a_if_req), .if_addr(a_if_addr),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .ld_req(a_ld_req), .ld_we(a_ld_we), .ld_addr(a_ld_addr), .ld_wdata(a_ld_wdata),
        .if_gnt(a_if_gnt), .dm_gnt(a_dm_gnt), .ld_gnt(a_ld_gnt),
        .if_done(a_if_done), .dm_done(a_dm_done), .ld_done(a_ld_done),
        .rdata(a_rdata), .busy(a_busy), .owner(a_owner),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    // ---- DUT b (LAT=3), data port only ----
    logic        b_dm_req;
    logic [31:0] b_dm_addr;
    logic        b_if_gnt, b_dm_gnt, b_ld_gnt, b_if_done, b_dm_done, b_ld_done;
    logic [31:0] b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic        b_busy, b_mem_en, b_mem_we;
    logic [1:0]  b_owner;

    mem_port_arbiter #(.AW(32), .DW(32), .LAT(3)) u_b (
        .clk(clk), .rst(rst),
        .if_req(1'b0), .if_addr(32'h0),
        .dm_req(b_dm_req), .dm_we(1'b0), .dm_addr(b_dm_addr), .dm_wdata(32'h0),
        .ld_req(1'b0), .ld_we(1'b0), .ld_addr(32'h0), .ld_wdata(32'h0),
        .if_gnt(b_if_gnt), .dm_gnt(b_dm_gnt), .ld_gnt(b_ld_gnt),
        .if_done(b_if_done), .dm_done(b_dm_done), .ld_done(b_ld_done),
        .rdata(b_rdata), .busy(b_busy), .owner(b_owner),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    // ---- RAM models ----
    logic [31:0] ram_a [0:255];
    logic [31:0] ram_b [0:255];
    logic [31:0] a_rd;
    logic [31:0] b_rd0, b_rd1, b_rd2;

    always @(posedge clk) begin
        if (rst) ram_a[8'h10] <= 32'hDEADBEEF;
        else if (a_mem_en && a_mem_we) ram_a[a_mem_addr[7:0]] <= a_mem_wdata;
        a_rd <= (a_mem_en && !a_mem_we) ? ram_a[a_mem_addr[7:0]] : 32'h0;
    end
    assign a_mem_rdata = a_rd;

    always @(posedge clk) begin
        if (rst) ram_b[8'h30] <= 32'hCAFEF00D;
        else if (b_mem_en && b_mem_we) ram_b[b_mem_addr[7:0]] <= b_mem_wdata;
        b_rd0 <= (b_mem_en && !b_mem_we) ? ram_b[b_mem_addr[7:0]] : 32'h0;
        b_rd1 <= b_rd0;
        b_rd2 <= b_rd1;
    end
    assign b_mem_rdata = b_rd2;

    int nvec  = 0;
    int nfail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns {ld,dm,if} grant vector of the first grant seen, 0 on timeout.
    task automatic wait_gnt(output logic [2:0] g);
        g = 3'b000;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (a_if_gnt || a_dm_gnt || a_ld_gnt) begin
                g = {a_ld_gnt, a_dm_gnt, a_if_gnt};
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g;
        rst = 1'b1;
        a_if_req = 0; a_dm_req = 0; a_dm_we = 0; a_ld_req = 0; a_ld_we = 0;
        a_if_addr = 0; a_dm_addr = 0; a_dm_wdata = 0; a_ld_addr = 0; a_ld_wdata = 0;
        b_dm_req = 0; b_dm_addr = 0;
        tick(); tick(); tick();

        // Reset state
        chk("rst gnt/done", {26'h0, a_ld_gnt, a_dm_gnt, a_if_gnt, a_ld_done, a_dm_done, a_if_done}, 32'h0);
        chk("rst busy/owner", {29'h0, a_busy, a_owner}, 32'h0);
        chk("rst rdata", a_rdata, 32'h0);
        chk("rst mem ctl", {30'h0, a_mem_en, a_mem_we}, 32'h0);
        chk("rst mem addr", a_mem_addr, 32'h0);
        rst = 1'b0;
        tick();

        // Single fetch read, LAT=1
        a_if_addr = 32'h10; a_if_req = 1;
        tick(); // T+1
        chk("if rd gnt", {29'h0, a_ld_gnt, a_dm_gnt, a_if_gnt}, 32'h1);
        chk("if rd mem ctl", {30'h0, a_mem_en, a_mem_we}, 32'h2);
        chk("if rd mem addr", a_mem_addr, 32'h10);
        chk("if rd busy/owner", {29'h0, a_busy, a_owner}, 32'h5);
        tick(); // T+2 WAIT
        chk("if rd T2 quiet", {27'h0, a_mem_en, a_if_gnt, a_if_done, a_dm_done, a_ld_done}, 32'h0);
        chk("if rd T2 busy", {31'h0, a_busy}, 32'h1);
        tick(); // T+3 DONE
        chk("if rd done", {29'h0, a_ld_done, a_dm_done, a_if_done}, 32'h1);
        chk("if rd data", a_rdata, 32'hDEADBEEF);
        chk("if rd T3 mem_en", {31'h0, a_mem_en}, 32'h0);
        a_if_req = 0;
        tick(); // T+4 IDLE
        chk("if rd idle", {27'h0, a_if_done, a_busy, a_owner}, 32'h0);

        // Data write then fetch read of the same address
        a_dm_addr = 32'h20; a_dm_we = 1; a_dm_wdata = 32'h12345678; a_dm_req = 1;
        tick();
        chk("dm wr gnt", {29'h0, a_ld_gnt, a_dm_gnt, a_if_gnt}, 32'h2);
        chk("dm wr mem ctl", {30'h0, a_mem_en, a_mem_we}, 32'h3);
        chk("dm wr mem addr", a_mem_addr, 32'h20);
        chk("dm wr mem wdata", a_mem_wdata, 32'h12345678);
        tick();
        chk("dm wr done T2", {29'h0, a_ld_done, a_dm_done, a_if_done}, 32'h2);
        chk("dm wr rdata kept", a_rdata, 32'hDEADBEEF);
        a_dm_req = 0; a_dm_we = 0;
        tick();
        chk("dm wr idle", {31'h0, a_busy}, 32'h0);
        a_if_addr = 32'h20; a_if_req = 1;
        tick(); tick(); tick();
        chk("rd back done", {29'h0, a_ld_done, a_dm_done, a_if_done}, 32'h1);
        chk("rd back data", a_rdata, 32'h12345678);
        a_if_req = 0;
        tick();

        // Round-robin with both requesting; loader cuts in
        a_if_addr = 32'h10; a_dm_addr = 32'h20; a_dm_we = 0;
        a_if_req = 1; a_dm_req = 1;
        wait_gnt(g); chk("rr 1st dm", {29'h0, g}, 32'h2);
        wait_gnt(g); chk("rr 2nd if", {29'h0, g}, 32'h1);
        a_ld_addr = 32'h10; a_ld_we = 0; a_ld_req = 1;
        wait_gnt(g); chk("rr ld wins", {29'h0, g}, 32'h4);
        chk("ld owner", {30'h0, a_owner}, 32'h3);
        tick(); tick();
        chk("ld done", {29'h0, a_ld_done, a_dm_done, a_if_done}, 32'h4);
        chk("ld data", a_rdata, 32'hDEADBEEF);
        a_ld_req = 0;
        wait_gnt(g); chk("rr 3rd dm", {29'h0, g}, 32'h2);
        wait_gnt(g); chk("rr 4th if", {29'h0, g}, 32'h1);
        a_if_req = 0; a_dm_req = 0;
        tick(); tick();
        chk("if done after drop", {29'h0, a_ld_done, a_dm_done, a_if_done}, 32'h1);
        tick();
        chk("rr idle", {31'h0, a_busy}, 32'h0);

        // Data read with req dropped right after the grant
        a_dm_addr = 32'h10; a_dm_we = 0; a_dm_req = 1;
        tick();
        chk("drop gnt", {29'h0, a_ld_gnt, a_dm_gnt, a_if_gnt}, 32'h2);
        a_dm_req = 0; a_dm_addr = 32'h99;
        tick(); tick();
        chk("drop done", {29'h0, a_ld_done, a_dm_done, a_if_done}, 32'h2);
        chk("drop data", a_rdata, 32'hDEADBEEF);
        tick();

        // LAT=3 read on DUT b
        b_dm_addr = 32'h30; b_dm_req = 1;
        tick(); // T+1
        chk("lat3 gnt", {26'h0, b_ld_gnt, b_dm_gnt, b_if_gnt, b_ld_done, b_dm_done, b_if_done}, 32'h10);
        chk("lat3 owner/busy", {29'h0, b_busy, b_owner}, 32'h6);
        for (int i = 0; i < 3; i++) begin
            tick(); // T+2..T+4
            chk("lat3 wait", {28'h0, b_busy, b_ld_done, b_dm_done, b_if_done}, 32'h8);
        end
        tick(); // T+5
        chk("lat3 done", {28'h0, b_busy, b_ld_done, b_dm_done, b_if_done}, 32'hA);
        chk("lat3 data", b_rdata, 32'hCAFEF00D);
        b_dm_req = 0;
        tick();
        chk("lat3 idle", {29'h0, b_busy, b_owner}, 32'h0);

        // Reset during WAIT on DUT a
        a_if_addr = 32'h20; a_if_req = 1;
        tick(); tick(); // T+2 WAIT
        rst = 1'b1;
        #1;
        chk("mid rst flags", {24'h0, a_busy, a_owner, a_mem_en, a_if_gnt, a_if_done, a_dm_done, a_ld_done}, 32'h0);
        chk("mid rst rdata", a_rdata, 32'h0);
        a_if_req = 0;
        tick();
        chk("mid rst no done", {29'h0, a_ld_done, a_dm_done, a_if_done}, 32'h0);
        rst = 1'b0;
        tick();
        chk("post rst idle", {28'h0, a_busy, a_ld_done, a_dm_done, a_if_done}, 32'h0);
        a_dm_addr = 32'h20; a_dm_we = 0; a_dm_req = 1;
        tick();
        chk("post rst gnt", {29'h0, a_ld_gnt, a_dm_gnt, a_if_gnt}, 32'h2);
        tick(); tick();
        chk("post rst done", {29'h0, a_ld_done, a_dm_done, a_if_done}, 32'h2);
        chk("post rst data", a_rdata, 32'h12345678);
        a_dm_req = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
